dm_responder: RTL

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_if.sv | 17 +
 rtl/dm_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dm_responder_if.sv
// dm_responder_if: request/response bus between an initiator and dm_responder.
// Signals: req, we, addr[9:0], wdata[31:0] and be[3:0] are driven by the initiator.
//          ack, rdata[31:0], err and busy are driven by the responder.
// Modports: master is the initiator side, slave is the responder side.
interface dm_responder_if;
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    modport master (output req, we, addr, wdata, be, input ack, rdata, err, busy);
    modport slave (input req, we, addr, wdata, be, output ack, rdata, err, busy);
endinterface

// File: rtl/dm_responder.sv
// dm_responder: word-organised memory slave that answers each request after a fixed number of wait states.
// Ports: clk (rising-edge clock); reset (synchronous, active-low);
//        bus (dm_responder_if.slave): req/we/addr/wdata/be in, ack/rdata/err/busy out.
// Parameters: WAIT_CYCLES (0-15) wait states between acceptance and response; DEPTH words of storage.
// Macro DM_BYTE_EN_EN: when defined, aligned stores write only the byte lanes selected by be;
//        when undefined, be is ignored and every aligned store writes the full word.
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input logic           clk,
    input logic           reset,
    dm_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [9:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [DEPTH];
    logic          cur_we;
    logic [9:0]    cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic [3:0]    wmask;
    logic [AW-1:0] idx;
    logic          misaligned;
    logic          go_resp;
    logic          mem_wr;

    // With zero wait states the transaction resolves on its acceptance edge, before
    // anything is latched, so in IDLE the live bus values stand in for the latched ones.
    always_comb begin
        cur_we     = (state_q == IDLE) ? bus.we    : we_q;
        cur_addr   = (state_q == IDLE) ? bus.addr  : addr_q;
        cur_wdata  = (state_q == IDLE) ? bus.wdata : wdata_q;
        cur_be     = (state_q == IDLE) ? bus.be    : be_q;
        misaligned = cur_addr[1:0] != 2'b00;
        idx        = AW'({24'd0, cur_addr[9:2]} % DEPTH);
`ifdef DM_BYTE_EN_EN
        wmask      = cur_be;
`else
        // be is deliberately ignored: every byte lane is forced on.
        wmask      = cur_be | 4'hF;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) go_resp = 1'b1;
                else cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Response values are registered on the edge entering RESP so ack/err/rdata come straight from flops.
        if (go_resp) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            ack_d   = 1'b1;
            err_d   = misaligned;
            rdata_d = (!misaligned && !cur_we) ? mem[idx] : '0;
        end
    end

    // Gating with reset keeps a store that is abandoned by reset out of memory.
    assign mem_wr = reset && go_resp && cur_we && !misaligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
endmodule
